fetch_regfile_unit: RTL and testbench

Parametrised fetch and register-file stage for the single-cycle RISC-V core. It holds the program counter, an internal loadable instruction memory, rs1/rs2/rd field decode, and a multi-register file with write-through bypass. It extends the fixed 8-bit PC/regfile datapath with:
- configurable widths and depths;
- redirect (branch/jump) and stall control;
- misalignment flagging;
- a retired-instruction counter.

It feeds the ALU/control stage and takes writeback from it.

---
 rtl/fetch_regfile_unit_if.sv | 72 +++++++
 rtl/fetch_regfile_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_regfile_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_regfile_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_regfile_unit_if
//
// Purpose:
//    This interface bundles the control, instruction-load, writeback and
//    fetch/decode/read signals of the fetch and register-file stage. The clock
//    and reset are not part of it; they stay plain ports on the stage.
//
// Modports:
//    master : the side that drives the stage. This is the control/ALU stage
//             or a testbench. It drives stall, redirect, IMEM load and
//             writeback, and it observes the PC, the instruction, the decode
//             fields, the register data, misaligned and instret.
//    slave  : the fetch_regfile_unit itself.
//
// Parameters:
//    XLEN       : datapath and PC width (32 or 64).
//    NREG       : register count (16 or 32). AW = $clog2(NREG).
//    IMEM_DEPTH : instruction memory depth in 32-bit words.
//                 IW = $clog2(IMEM_DEPTH).
// -----------------------------------------------------------------------------
interface fetch_regfile_unit_if #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int IMEM_DEPTH = 256
);
   localparam int AW = $clog2(NREG);
   localparam int IW = $clog2(IMEM_DEPTH);

   // Control
   logic            stall;
   logic            redirect_en;
   logic [XLEN-1:0] redirect_pc;

   // Instruction memory load port
   logic            imem_wr_en;
   logic [IW-1:0]   imem_wr_addr;
   logic [31:0]     imem_wr_data;

   // Register writeback
   logic            rg_wrt_en;
   logic [AW-1:0]   rg_wrt_addr;
   logic [XLEN-1:0] write_data;

   // Fetch / decode / read results
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [31:0]     instr;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rg_rd_data1;
   logic [XLEN-1:0] rg_rd_data2;
   logic            misaligned;
   logic [XLEN-1:0] instret;

   modport master (
      output stall, redirect_en, redirect_pc,
      output imem_wr_en, imem_wr_addr, imem_wr_data,
      output rg_wrt_en, rg_wrt_addr, write_data,
      input  pc, pc_plus4, instr, rs1_addr, rs2_addr, rd_addr,
      input  rg_rd_data1, rg_rd_data2, misaligned, instret
   );

   modport slave (
      input  stall, redirect_en, redirect_pc,
      input  imem_wr_en, imem_wr_addr, imem_wr_data,
      input  rg_wrt_en, rg_wrt_addr, write_data,
      output pc, pc_plus4, instr, rs1_addr, rs2_addr, rd_addr,
      output rg_rd_data1, rg_rd_data2, misaligned, instret
   );
endinterface

// File: rtl/fetch_regfile_unit.sv
// -----------------------------------------------------------------------------
// fetch_regfile_unit
//
// Purpose:
//    This is the fetch and register-file stage of the single-cycle RISC-V core.
//    It holds the following:
//       - the program counter, with redirect and stall control and a flag for
//         misaligned redirects;
//       - a loadable instruction memory, read combinationally at the PC;
//       - the rs1/rs2/rd field decode;
//       - a register file with x0 hardwired to zero and write-through bypass;
//       - a counter of retired instructions.
//
// Ports:
//    clk   : rising-edge clock.
//    reset : asynchronous, active-low reset. It clears the PC to RESET_PC. It
//            also clears instret, misaligned and every register. It does not
//            clear the instruction memory.
//    bus   : fetch_regfile_unit_if.slave. It carries the control, IMEM load,
//            writeback, fetch, decode and read signals.
//
// Parameters:
//    XLEN, NREG, IMEM_DEPTH : these must match the bound interface instance.
//    RESET_PC               : the PC value after reset. It must be word aligned.
// -----------------------------------------------------------------------------
module fetch_regfile_unit #(
   parameter int              XLEN       = 32,
   parameter int              NREG       = 32,
   parameter int              IMEM_DEPTH = 256,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input logic                 clk,
   input logic                 reset,
   fetch_regfile_unit_if.slave bus
);

   localparam int          AW  = $clog2(NREG);
   localparam int          IW  = $clog2(IMEM_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;   // addi x0, x0, 0

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] pc_q,         pc_d;
   logic [XLEN-1:0] instret_q,    instret_d;
   logic            misaligned_q, misaligned_d;

   logic [31:0]     imem_q [IMEM_DEPTH];
   logic [XLEN-1:0] rf_q   [NREG];

   // ------------------------------------------------------------------------
   // Combinational datapath signals
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] pc_plus4;
   logic            pc_in_range;
   logic [31:0]     instr;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data1;
   logic [XLEN-1:0] rd_data2;
   logic            rf_wr;

   // Natural modulo-2^XLEN addition: the last aligned PC wraps to zero.
   assign pc_plus4 = pc_q + XLEN'(4);

   // ------------------------------------------------------------------------
   // Next-PC, misaligned flag and retired-instruction counter
   // Redirect has priority over stall. A stalled cycle retires nothing,
   // unless it is also redirected.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no
      // path through the ifs below can leave a latch behind.
      pc_d         = pc_q;
      misaligned_d = 1'b0;
      instret_d    = instret_q;

      if (bus.redirect_en) begin
         pc_d         = {bus.redirect_pc[XLEN-1:2], 2'b00};
         misaligned_d = |bus.redirect_pc[1:0];
      end else if (!bus.stall) begin
         pc_d = pc_plus4;
      end

      if (bus.redirect_en || !bus.stall) begin
         instret_d = instret_q + XLEN'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state is updated with <= so that every flop samples the
      // pre-edge values. Blocking assignment here would create
      // order-dependent races between blocks.
      if (!reset) begin
         pc_q         <= RESET_PC;
         instret_q    <= '0;
         misaligned_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         instret_q    <= instret_d;
         misaligned_q <= misaligned_d;
      end
   end

   // ------------------------------------------------------------------------
   // Instruction memory
   // ------------------------------------------------------------------------
   // NOTE: the instruction memory deliberately has no reset. Program contents
   // survive a core reset, and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (bus.imem_wr_en) begin
         imem_q[bus.imem_wr_addr] <= bus.imem_wr_data;
      end
   end

   // A PC beyond the memory fetches a NOP rather than an aliased word.
   assign pc_in_range = (pc_q[XLEN-1:2] < (XLEN-2)'(IMEM_DEPTH));

   always_comb begin
      instr = NOP;
      if (pc_in_range) begin
         instr = imem_q[pc_q[IW+1:2]];
      end
   end

   // ------------------------------------------------------------------------
   // Field decode. With NREG=16 the top bit of each field is dropped, so the
   // register addresses alias modulo 16.
   // ------------------------------------------------------------------------
   assign rs1_addr = instr[15 +: AW];
   assign rs2_addr = instr[20 +: AW];
   assign rd_addr  = instr[7  +: AW];

   // ------------------------------------------------------------------------
   // Register file
   // x0 is never written. Its storage stays at the reset value, and the read
   // muxes force it to zero regardless.
   // ------------------------------------------------------------------------
   assign rf_wr = bus.rg_wrt_en && (bus.rg_wrt_addr != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (rf_wr) begin
         rf_q[bus.rg_wrt_addr] <= bus.write_data;
      end
   end

   // Write-through bypass: a register being written this cycle reads back its
   // new value at once, so a dependent instruction needs no extra cycle.
   always_comb begin
      rd_data1 = '0;
      if (rs1_addr != '0) begin
         if (rf_wr && (bus.rg_wrt_addr == rs1_addr)) begin
            rd_data1 = bus.write_data;
         end else begin
            rd_data1 = rf_q[rs1_addr];
         end
      end
   end

   always_comb begin
      rd_data2 = '0;
      if (rs2_addr != '0) begin
         if (rf_wr && (bus.rg_wrt_addr == rs2_addr)) begin
            rd_data2 = bus.write_data;
         end else begin
            rd_data2 = rf_q[rs2_addr];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.instr       = instr;
   assign bus.rs1_addr    = rs1_addr;
   assign bus.rs2_addr    = rs2_addr;
   assign bus.rd_addr     = rd_addr;
   assign bus.rg_rd_data1 = rd_data1;
   assign bus.rg_rd_data2 = rd_data2;
   assign bus.misaligned  = misaligned_q;
   assign bus.instret     = instret_q;

endmodule

// File: tb/tb_fetch_regfile_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_regfile_unit
//
// This is a directed testbench for fetch_regfile_unit, using default
// parameters (XLEN=32, NREG=32, IMEM_DEPTH=256, RESET_PC=0).
//
// Each scenario task does the following:
//    - drives its stimulus just after a rising edge;
//    - lets it settle;
//    - compares outputs against hand-computed values before the next edge.
//
// exp_instret is advanced from the bench's own stall/redirect stimulus.
// -----------------------------------------------------------------------------
module tb_fetch_regfile_unit;

   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int IMEM_DEPTH = 256;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;
   logic [31:0] exp_instret;

   fetch_regfile_unit_if #(
      .XLEN      (XLEN),
      .NREG      (NREG),
      .IMEM_DEPTH(IMEM_DEPTH)
   ) bus ();

   fetch_regfile_unit #(
      .XLEN      (XLEN),
      .NREG      (NREG),
      .IMEM_DEPTH(IMEM_DEPTH),
      .RESET_PC  (32'h0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   // Advance one rising edge and update the expected retire count. The count
   // is driven only by the bench's own stall/redirect inputs.
   task automatic tick();
      if (bus.redirect_en || !bus.stall) exp_instret = exp_instret + 32'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset            = 1'b0;
      bus.stall        = 1'b1;
      bus.redirect_en  = 1'b0;
      bus.redirect_pc  = '0;
      bus.imem_wr_en   = 1'b0;
      bus.imem_wr_addr = '0;
      bus.imem_wr_data = '0;
      bus.rg_wrt_en    = 1'b0;
      bus.rg_wrt_addr  = '0;
      bus.write_data   = '0;
      exp_instret      = '0;
      #12;
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); end
      checks++; if (bus.instret !== 32'h0) begin errors++; $display("FAIL reset_instret got %h exp %h", bus.instret, 32'h0); end
      checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got %b exp 0", bus.misaligned); end
      checks++; if (bus.pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp %h", bus.pc_plus4, 32'h4); end
      reset = 1'b1;
      tick();
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL stall_after_reset_pc got %h exp %h", bus.pc, 32'h0); end
   endtask

   task automatic test_imem_load();
      logic [31:0] words [5];
      logic [7:0]  addrs [5];
      bus.imem_wr_en   = 1'b1;
      bus.imem_wr_addr = 8'd0;
      bus.imem_wr_data = 32'hDEAD_BEEF;
      tick();
      checks++; if (bus.instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL imem_first_write got %h exp %h", bus.instr, 32'hDEAD_BEEF); end
      // Overwrite the word under the PC: old data until the edge.
      bus.imem_wr_data = 32'h0010_0093;
      #1;
      checks++; if (bus.instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL imem_old_before_edge got %h exp %h", bus.instr, 32'hDEAD_BEEF); end
      tick();
      checks++; if (bus.instr !== 32'h0010_0093) begin errors++; $display("FAIL imem_new_after_edge got %h exp %h", bus.instr, 32'h0010_0093); end
      words[0] = 32'h0020_0113; addrs[0] = 8'd1;
      words[1] = 32'h0030_8193; addrs[1] = 8'd2;
      words[2] = 32'h0010_8193; addrs[2] = 8'd3;
      words[3] = 32'h00A0_0513; addrs[3] = 8'd255;
      words[4] = 32'h0000_0000; addrs[4] = 8'd16;
      for (int i = 0; i < 5; i++) begin
         bus.imem_wr_addr = addrs[i];
         bus.imem_wr_data = words[i];
         tick();
      end
      bus.imem_wr_en = 1'b0;
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL load_stall_pc got %h exp %h", bus.pc, 32'h0); end
      checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL load_stall_instret got %h exp %h", bus.instret, exp_instret); end
   endtask

   task automatic test_fetch_sequence();
      bus.stall = 1'b0;
      #1;
      checks++; if (bus.rs1_addr !== 5'd0 || bus.rd_addr !== 5'd1) begin errors++; $display("FAIL decode0 got rs1=%0d rd=%0d exp rs1=0 rd=1", bus.rs1_addr, bus.rd_addr); end
      bus.rg_wrt_en   = 1'b1;
      bus.rg_wrt_addr = 5'd1;
      bus.write_data  = 32'h1234_5678;
      #1;
      checks++; if (bus.rg_rd_data1 !== 32'h0) begin errors++; $display("FAIL x0_no_bypass got %h exp %h", bus.rg_rd_data1, 32'h0); end
      tick();
      bus.rg_wrt_en = 1'b0;
      #1;
      checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL step_pc4 got %h exp %h", bus.pc, 32'h4); end
      checks++; if (bus.instr !== 32'h0020_0113) begin errors++; $display("FAIL step_instr1 got %h exp %h", bus.instr, 32'h0020_0113); end
      checks++; if (bus.rd_addr !== 5'd2 || bus.rs2_addr !== 5'd2) begin errors++; $display("FAIL decode1 got rd=%0d rs2=%0d exp rd=2 rs2=2", bus.rd_addr, bus.rs2_addr); end
      tick();
      checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL step_pc8 got %h exp %h", bus.pc, 32'h8); end
      checks++; if (bus.instr !== 32'h0030_8193) begin errors++; $display("FAIL step_instr2 got %h exp %h", bus.instr, 32'h0030_8193); end
      checks++; if (bus.rg_rd_data1 !== 32'h1234_5678) begin errors++; $display("FAIL x1_from_storage got %h exp %h", bus.rg_rd_data1, 32'h1234_5678); end
      checks++; if (bus.rg_rd_data2 !== 32'h0) begin errors++; $display("FAIL x3_unwritten got %h exp %h", bus.rg_rd_data2, 32'h0); end
      tick();
      checks++; if (bus.pc !== 32'hC) begin errors++; $display("FAIL step_pc12 got %h exp %h", bus.pc, 32'hC); end
      checks++; if (bus.instret !== 32'd3 || exp_instret !== 32'd3) begin errors++; $display("FAIL instret_after_3 got %0d exp 3", bus.instret); end
      bus.stall = 1'b1;
   endtask

   task automatic test_regfile();
      // pc=12: instr 00108193 has rs1=1 and rs2=1
      #1;
      checks++; if (bus.rg_rd_data2 !== 32'h1234_5678) begin errors++; $display("FAIL rs2_storage got %h exp %h", bus.rg_rd_data2, 32'h1234_5678); end
      bus.rg_wrt_en   = 1'b1;
      bus.rg_wrt_addr = 5'd1;
      bus.write_data  = 32'hA5A5_A5A5;
      #1;
      checks++; if (bus.rg_rd_data1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_rs1 got %h exp %h", bus.rg_rd_data1, 32'hA5A5_A5A5); end
      checks++; if (bus.rg_rd_data2 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_rs2 got %h exp %h", bus.rg_rd_data2, 32'hA5A5_A5A5); end
      tick();
      bus.rg_wrt_en = 1'b0;
      #1;
      checks++; if (bus.rg_rd_data1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL write_stored got %h exp %h", bus.rg_rd_data1, 32'hA5A5_A5A5); end
      // Move to pc=4 (rs1=x0) and try to write x0.
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h4;
      tick();
      bus.redirect_en = 1'b0;
      checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL redirect_pc4 got %h exp %h", bus.pc, 32'h4); end
      bus.rg_wrt_en   = 1'b1;
      bus.rg_wrt_addr = 5'd0;
      bus.write_data  = 32'hFFFF_FFFF;
      #1;
      checks++; if (bus.rg_rd_data1 !== 32'h0) begin errors++; $display("FAIL x0_write_bypass got %h exp %h", bus.rg_rd_data1, 32'h0); end
      tick();
      bus.rg_wrt_en = 1'b0;
      #1;
      checks++; if (bus.rg_rd_data1 !== 32'h0) begin errors++; $display("FAIL x0_reads_zero got %h exp %h", bus.rg_rd_data1, 32'h0); end
   endtask

   task automatic test_redirect();
      bus.stall       = 1'b1;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h0000_0042;
      tick();
      bus.redirect_en = 1'b0;
      checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL redirect_aligned_pc got %h exp %h", bus.pc, 32'h40); end
      checks++; if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_set got %b exp 1", bus.misaligned); end
      checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL redirect_instret got %h exp %h", bus.instret, exp_instret); end
      tick();
      checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL misaligned_one_cycle got %b exp 0", bus.misaligned); end
      checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL stalled_after_redirect got %h exp %h", bus.pc, 32'h40); end
   endtask

   task automatic test_stall();
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h8;
      tick();
      bus.redirect_en = 1'b0;
      checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL aligned_redirect_flag got %b exp 0", bus.misaligned); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.pc !== 32'h8 || bus.instr !== 32'h0030_8193 || bus.instret !== exp_instret) begin
            errors++;
            $display("FAIL stall_hold[%0d] got pc=%h instr=%h instret=%h exp pc=%h instr=%h instret=%h",
                     i, bus.pc, bus.instr, bus.instret, 32'h8, 32'h0030_8193, exp_instret);
         end
      end
   endtask

   task automatic test_boundaries();
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'd1020;
      tick();
      checks++; if (bus.instr !== 32'h00A0_0513) begin errors++; $display("FAIL last_word_fetch got %h exp %h", bus.instr, 32'h00A0_0513); end
      bus.redirect_pc = 32'd1024;
      tick();
      checks++; if (bus.instr !== 32'h0000_0013) begin errors++; $display("FAIL past_end_nop got %h exp %h", bus.instr, 32'h0000_0013); end
      bus.redirect_pc = 32'hFFFF_FFFC;
      tick();
      bus.redirect_en = 1'b0;
      checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL pc_plus4_wrap got %h exp %h", bus.pc_plus4, 32'h0); end
      checks++; if (bus.instr !== 32'h0000_0013) begin errors++; $display("FAIL top_pc_nop got %h exp %h", bus.instr, 32'h0000_0013); end
      bus.stall = 1'b0;
      tick();
      bus.stall = 1'b1;
      checks++; if (bus.pc !== 32'h0 || bus.instret !== exp_instret) begin
         errors++;
         $display("FAIL pc_wrap_step got pc=%h instret=%h exp pc=%h instret=%h", bus.pc, bus.instret, 32'h0, exp_instret);
      end
   endtask

   task automatic test_reset_midrun();
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h43;
      tick();
      bus.redirect_en = 1'b0;
      checks++; if (bus.misaligned !== 1'b1 || bus.pc !== 32'h40) begin errors++; $display("FAIL pre_reset_state got pc=%h mis=%b exp pc=40 mis=1", bus.pc, bus.misaligned); end
      #2;
      reset = 1'b0;
      exp_instret = '0;
      #1;
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL midrun_reset_pc got %h exp %h", bus.pc, 32'h0); end
      checks++; if (bus.instret !== 32'h0) begin errors++; $display("FAIL midrun_reset_instret got %h exp %h", bus.instret, 32'h0); end
      checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL midrun_reset_misaligned got %b exp 0", bus.misaligned); end
      // instr at pc=0 is 00100093, whose rs2 field selects x1 (was A5A5A5A5).
      checks++; if (bus.rs2_addr !== 5'd1 || bus.rg_rd_data2 !== 32'h0) begin
         errors++;
         $display("FAIL midrun_reset_x1 got rs2=%0d data=%h exp rs2=1 data=%h", bus.rs2_addr, bus.rg_rd_data2, 32'h0);
      end
      #1;
      reset = 1'b1;
      tick();
      checks++; if (bus.instr !== 32'h0010_0093 || bus.pc !== 32'h0 || bus.instret !== exp_instret) begin
         errors++;
         $display("FAIL imem_kept_after_reset got pc=%h instr=%h instret=%h exp pc=%h instr=%h instret=%h",
                  bus.pc, bus.instr, bus.instret, 32'h0, 32'h0010_0093, exp_instret);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_imem_load();
      test_fetch_sequence();
      test_regfile();
      test_redirect();
      test_stall();
      test_boundaries();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
